adc_capture: RTL and testbench



---
 rtl/adc_capture.sv | 181 ++++++++++++++++++
 tb/tb_adc_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - dual-channel serial ADC capture controller
module adc_capture #(
  parameter int CLK_DIV      = 5,
  parameter int NUM_SAMPLES  = 128,
  parameter int QUIET_CYCLES = 1
) (
  input  logic        fpga_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        serial_data1,
  input  logic        serial_data2,
  output logic        ADC_clk,
  output logic        chip_select,
  output logic [11:0] sample1,
  output logic [11:0] sample2,
  output logic [6:0]  sample_index,
  output logic        sample_valid,
  output logic        sample_err,
  output logic        frame_done,
  output logic        busy
);

  // One timer serves both the ADC_clk half-period and the quiet gap,
  // so it is sized for the longer of the two (the quiet gap is >= 2*CLK_DIV).
  localparam int QUIET_LEN = QUIET_CYCLES * 2 * CLK_DIV;
  localparam int TW        = $clog2(QUIET_LEN + 1);

  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_LEN - 1);
  localparam logic [6:0]    LAST_IDX   = 7'(NUM_SAMPLES - 1);
  localparam logic [4:0]    RISES      = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    QUIET
  } state_t;

  state_t      state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [4:0]  rise_cnt, rise_cnt_n;
  logic [6:0]  conv_cnt, conv_cnt_n;
  logic [15:0] shift1, shift1_n;
  logic [15:0] shift2, shift2_n;
  logic [11:0] sample1_n, sample2_n;
  logic [6:0]  sample_index_n;
  logic        adc_clk_n, chip_select_n, valid_n, err_n, done_n, busy_n;
  logic        lead_err;

  // The four leading bits of each 16-bit frame must be zero on both channels.
  assign lead_err = (|shift1[15:12]) | (|shift2[15:12]);

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_n        = state;
    timer_n        = timer;
    rise_cnt_n     = rise_cnt;
    conv_cnt_n     = conv_cnt;
    shift1_n       = shift1;
    shift2_n       = shift2;
    sample1_n      = sample1;
    sample2_n      = sample2;
    sample_index_n = sample_index;
    adc_clk_n      = ADC_clk;
    chip_select_n  = chip_select;
    err_n          = sample_err;
    busy_n         = busy;
    valid_n        = 1'b0;
    done_n         = 1'b0;

    case (state)
      IDLE: begin
        conv_cnt_n = '0;
        timer_n    = '0;
        if (start) begin
          state_n       = CS_SETUP;
          chip_select_n = 1'b0;
          busy_n        = 1'b1;
        end
      end

      CS_SETUP: begin
        if (timer == DIV_LAST) begin
          timer_n    = '0;
          adc_clk_n  = 1'b0;
          rise_cnt_n = '0;
          state_n    = SHIFT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      SHIFT: begin
        if (rise_cnt == RISES) begin
          // End of conversion: publish the pair and release the ADCs.
          sample1_n      = shift1[11:0];
          sample2_n      = shift2[11:0];
          sample_index_n = conv_cnt;
          err_n          = lead_err;
          valid_n        = 1'b1;
          done_n         = (conv_cnt == LAST_IDX);
          chip_select_n  = 1'b1;
          timer_n        = '0;
          state_n        = QUIET;
        end else if (timer == DIV_LAST) begin
          timer_n   = '0;
          adc_clk_n = ~ADC_clk;
          if (!ADC_clk) begin
            // Data has been stable since the preceding falling edge.
            shift1_n   = {shift1[14:0], serial_data1};
            shift2_n   = {shift2[14:0], serial_data2};
            rise_cnt_n = rise_cnt + 5'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      QUIET: begin
        if (timer == QUIET_LAST) begin
          timer_n = '0;
          if (conv_cnt == LAST_IDX) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            conv_cnt_n    = conv_cnt + 7'd1;
            chip_select_n = 1'b0;
            state_n       = CS_SETUP;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath and output registers; reset abandons any partial conversion.
  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      rise_cnt     <= '0;
      conv_cnt     <= '0;
      shift1       <= '0;
      shift2       <= '0;
      sample1      <= '0;
      sample2      <= '0;
      sample_index <= '0;
      ADC_clk      <= 1'b1;
      chip_select  <= 1'b1;
      sample_valid <= 1'b0;
      sample_err   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      timer        <= timer_n;
      rise_cnt     <= rise_cnt_n;
      conv_cnt     <= conv_cnt_n;
      shift1       <= shift1_n;
      shift2       <= shift2_n;
      sample1      <= sample1_n;
      sample2      <= sample2_n;
      sample_index <= sample_index_n;
      ADC_clk      <= adc_clk_n;
      chip_select  <= chip_select_n;
      sample_valid <= valid_n;
      sample_err   <= err_n;
      frame_done   <= done_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - self-checking bench for adc_capture
module tb_adc_capture;

  localparam int N = 3;

  logic fpga_clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start_v[N];
  logic        adc_clk_v[N], cs_v[N], sd1_v[N], sd2_v[N];
  logic [11:0] s1_v[N], s2_v[N];
  logic [6:0]  idx_v[N];
  logic        valid_v[N], err_v[N], done_v[N], busy_v[N];
  int          mode_v[N];
  int          strobes_v[N], dones_v[N], rises_v[N];

  always #5 fpga_clk = ~fpga_clk;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Instance 0: defaults; 1: single-sample frame; 2: fast clock, 4-sample frame.
  for (genvar g = 0; g < N; g++) begin : inst
    localparam int CD = (g == 2) ? 2 : 5;
    localparam int NS = (g == 0) ? 128 : ((g == 1) ? 1 : 4);
    localparam int QL = 2 * CD;

    adc_capture #(.CLK_DIV(CD), .NUM_SAMPLES(NS), .QUIET_CYCLES(1)) dut (
      .fpga_clk     (fpga_clk),
      .reset        (reset),
      .start        (start_v[g]),
      .serial_data1 (sd1_v[g]),
      .serial_data2 (sd2_v[g]),
      .ADC_clk      (adc_clk_v[g]),
      .chip_select  (cs_v[g]),
      .sample1      (s1_v[g]),
      .sample2      (s2_v[g]),
      .sample_index (idx_v[g]),
      .sample_valid (valid_v[g]),
      .sample_err   (err_v[g]),
      .frame_done   (done_v[g]),
      .busy         (busy_v[g])
    );

    logic        cs_q = 1'b1, ck_q = 1'b1, busy_q = 1'b0;
    int          t_cs = 0, t_prev_cs = -1, t_tr = 0, t_done = 0, conv_n = 0, rise_n = 0, bp = 0;
    logic [15:0] w1, w2;
    logic [11:0] q1[$], q2[$];
    logic        qe[$];
    int          qi[$];
    logic [11:0] e1, e2;
    logic        ee;
    int          ei;

    // ADC model plus scoreboard, sampled on the falling fpga_clk edge.
    always @(negedge fpga_clk) begin
      if (reset) begin
        q1.delete(); q2.delete(); qe.delete(); qi.delete();
        cs_q = 1'b1; ck_q = 1'b1; busy_q = 1'b0;
        t_prev_cs = -1; conv_n = 0; rise_n = 0; rises_v[g] = 0;
        sd1_v[g] = 1'b0; sd2_v[g] = 1'b0;
      end else begin
        if (busy_v[g] && !busy_q) begin
          conv_n = 0;
          t_prev_cs = -1;
        end
        if (busy_q && !busy_v[g]) check("busy_fall_latency", cyc - t_done, QL);

        if (cs_q && !cs_v[g]) begin
          if (t_prev_cs >= 0) check("conv_period", cyc - t_prev_cs, 32 * CD + 1 + QL);
          t_prev_cs = cyc; t_cs = cyc; t_tr = cyc; rise_n = 0; bp = 15;
          case (mode_v[g])
            1: begin
              w1 = 16'(conv_n);
              w2 = 16'($urandom) & 16'h0FFF;
            end
            2: begin
              w1 = 16'h0A5C;
              w2 = 16'h035A;
            end
            3: begin
              w1 = 16'($urandom) & 16'h0FFF;
              w2 = 16'($urandom) & 16'h0FFF;
              if (conv_n == 1) w2[13] = 1'b1;
            end
            default: begin
              w1 = 16'($urandom);
              w2 = 16'($urandom);
              if ($urandom_range(0, 3) != 0) w1[15:12] = 4'h0;
              if ($urandom_range(0, 3) != 0) w2[15:12] = 4'h0;
            end
          endcase
          q1.push_back(w1[11:0]);
          q2.push_back(w2[11:0]);
          qe.push_back((w1[15:12] != 4'h0) || (w2[15:12] != 4'h0));
          qi.push_back(conv_n);
          conv_n++;
        end

        if (ck_q != adc_clk_v[g]) begin
          check("adc_half_period", cyc - t_tr, CD);
          t_tr = cyc;
          if (adc_clk_v[g]) begin
            rise_n++;
          end else if (bp >= 0) begin
            sd1_v[g] = w1[bp];
            sd2_v[g] = w2[bp];
            bp--;
          end
        end
        rises_v[g] = rise_n;

        if (!cs_q && cs_v[g]) check("rises_per_window", rise_n, 16);
        if (cs_v[g]) check("adc_clk_high_when_cs_high", adc_clk_v[g], 1'b1);

        if (valid_v[g]) begin
          strobes_v[g]++;
          check("valid_latency", cyc - t_cs, 32 * CD + 1);
          check("valid_has_expected", q1.size() != 0, 1'b1);
          if (q1.size() != 0) begin
            e1 = q1.pop_front(); e2 = q2.pop_front(); ee = qe.pop_front(); ei = qi.pop_front();
            check("sample1", s1_v[g], e1);
            check("sample2", s2_v[g], e2);
            check("sample_err", err_v[g], ee);
            check("sample_index", idx_v[g], ei);
            check("frame_done_flag", done_v[g], ei == NS - 1);
          end
        end
        if (done_v[g]) begin
          dones_v[g]++;
          t_done = cyc;
          check("done_with_valid", valid_v[g], 1'b1);
        end

        cs_q = cs_v[g]; ck_q = adc_clk_v[g]; busy_q = busy_v[g];
      end
    end
  end

  task automatic check_reset_vals(input int g);
    check("rst_cs", cs_v[g], 1'b1);
    check("rst_adc_clk", adc_clk_v[g], 1'b1);
    check("rst_sample1", s1_v[g], 12'h0);
    check("rst_sample2", s2_v[g], 12'h0);
    check("rst_index", idx_v[g], 7'h0);
    check("rst_valid", valid_v[g], 1'b0);
    check("rst_err", err_v[g], 1'b0);
    check("rst_done", done_v[g], 1'b0);
    check("rst_busy", busy_v[g], 1'b0);
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n = 0;
    while (busy_v[g] && n < budget) begin
      @(negedge fpga_clk); #1;
      n++;
    end
    check("frame_timeout", busy_v[g], 1'b0);
  endtask

  task automatic pulse_start(input int g, input logic hold);
    @(negedge fpga_clk);
    start_v[g] = 1'b1;
    @(negedge fpga_clk);
    if (!hold) start_v[g] = 1'b0;
    #1;
    check("start_busy", busy_v[g], 1'b1);
    check("start_cs_low", cs_v[g], 1'b0);
  endtask

  initial begin
    int s0, d0, n;
    reset = 1'b1;
    for (int g = 0; g < N; g++) begin
      start_v[g] = 1'b0; mode_v[g] = 0; strobes_v[g] = 0; dones_v[g] = 0;
      rises_v[g] = 0; sd1_v[g] = 1'b0; sd2_v[g] = 1'b0;
    end
    repeat (3) @(posedge fpga_clk);
    #1;
    for (int g = 0; g < N; g++) check_reset_vals(g);
    @(negedge fpga_clk);
    reset = 1'b0;

    // Single-sample frame with fixed words.
    mode_v[1] = 2;
    s0 = strobes_v[1]; d0 = dones_v[1];
    pulse_start(1, 1'b0);
    wait_idle(1, 2000);
    check("nsamp1_strobes", strobes_v[1] - s0, 1);
    check("nsamp1_dones", dones_v[1] - d0, 1);
    check("nsamp1_s1_hold", s1_v[1], 12'hA5C);
    check("nsamp1_s2_hold", s2_v[1], 12'h35A);
    check("nsamp1_err_hold", err_v[1], 1'b0);

    // Reset after rising edge 7 of the first conversion.
    mode_v[0] = 0;
    pulse_start(0, 1'b0);
    n = 0;
    while (rises_v[0] < 7 && n < 2000) begin
      @(negedge fpga_clk); #1;
      n++;
    end
    check("reach_rise7", rises_v[0], 7);
    #1 reset = 1'b1;
    #1;
    check_reset_vals(0);
    check("rst_other_sample1", s1_v[1], 12'h0);
    repeat (2) @(negedge fpga_clk);
    reset = 1'b0;
    s0 = strobes_v[0];
    repeat (400) @(negedge fpga_clk);
    #1;
    check("no_strobe_after_reset", strobes_v[0] - s0, 0);
    check("idle_after_reset", busy_v[0], 1'b0);

    // Full default frame with incrementing ch1 data.
    mode_v[0] = 1;
    s0 = strobes_v[0]; d0 = dones_v[0];
    pulse_start(0, 1'b0);
    wait_idle(0, 30000);
    check("frame128_strobes", strobes_v[0] - s0, 128);
    check("frame128_dones", dones_v[0] - d0, 1);
    check("frame128_last_index", idx_v[0], 7'd127);

    // Fast clock, leading-bit error on conversion 1, start held high throughout.
    mode_v[2] = 3;
    s0 = strobes_v[2]; d0 = dones_v[2];
    pulse_start(2, 1'b1);
    wait_idle(2, 2000);
    check("held_strobes", strobes_v[2] - s0, 4);
    check("held_dones", dones_v[2] - d0, 1);
    @(negedge fpga_clk); #1;
    check("restart_first_idle_cycle", busy_v[2], 1'b1);
    start_v[2] = 1'b0;
    mode_v[2] = 0;
    s0 = strobes_v[2];
    wait_idle(2, 2000);
    check("random_frame_strobes", strobes_v[2] - s0, 4);

    repeat (5) @(negedge fpga_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
